// File: rtl/matrix_strip_rx.sv
// Two-wire LED-strip receiver: hunts the all-zero start frame, then deserialises 32-bit LED words.
// Optional build macro MATRIX_RX_SNAKE_EN remaps pix_index to undo serpentine row wiring.
module matrix_strip_rx #(
    parameter int NUM_LEDS     = 64,
    parameter int START_BITS   = 32,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk_in,
    input  logic        sdat_in,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic [5:0]  pix_index,
    output logic        frame_done,
    output logic        frame_error,
    output logic        in_frame
);
    localparam int ZW = $clog2(START_BITS + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_PIXEL = 2'd2;
    localparam logic [1:0] ST_TAIL  = 2'd3;

    localparam logic [5:0]    LAST_WORD = 6'(NUM_LEDS - 1);
    localparam logic [ZW-1:0] ZERO_LAST = ZW'(START_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(IDLE_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          sclk_q;
    logic [31:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [5:0]    word_cnt_q, word_cnt_d;
    logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   pix_data_q, pix_data_d;
    logic [5:0]    pix_index_q, pix_index_d;
    logic          pix_valid_q, pix_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_error_q, frame_error_d;

    logic          bit_event;
    logic [31:0]   word_w;

    function automatic logic [5:0] map_index(input logic [5:0] i);
`ifdef MATRIX_RX_SNAKE_EN
        // Even rows run right-to-left on the strip, so mirror the column.
        return i[3] ? i : {i[5:3], ~i[2:0]};
`else
        return i;
`endif
    endfunction

    assign bit_event = sclk_q & ~sclk_in;
    assign word_w    = {shift_q[30:0], sdat_in};

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        zero_cnt_d    = zero_cnt_q;
        tmo_d         = tmo_q;
        pix_data_d    = pix_data_q;
        pix_index_d   = pix_index_q;
        pix_valid_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        if (bit_event) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE, ST_TAIL: begin
                    if (sdat_in) begin
                        zero_cnt_d = '0;
                    end else if (zero_cnt_q == ZERO_LAST) begin
                        zero_cnt_d = '0;
                        state_d    = ST_SYNC;
                    end else begin
                        zero_cnt_d = zero_cnt_q + ZW'(1);
                    end
                end
                ST_SYNC: begin
                    if (sdat_in) begin
                        shift_d    = 32'd1;
                        bit_cnt_d  = 5'd1;
                        word_cnt_d = '0;
                        state_d    = ST_PIXEL;
                    end
                end
                default: begin
                    shift_d   = word_w;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        if (word_w[31:29] == 3'b111) begin
                            pix_valid_d = 1'b1;
                            pix_data_d  = word_w;
                            pix_index_d = map_index(word_cnt_q);
                            word_cnt_d  = word_cnt_q + 6'd1;
                            if (word_cnt_q == LAST_WORD) begin
                                frame_done_d = 1'b1;
                                word_cnt_d   = '0;
                                zero_cnt_d   = '0;
                                state_d      = ST_TAIL;
                            end
                        end else begin
                            // An all-zero word is a fresh start frame; anything else is garbage.
                            frame_error_d = 1'b1;
                            word_cnt_d    = '0;
                            zero_cnt_d    = '0;
                            state_d       = (word_w == 32'd0) ? ST_SYNC : ST_IDLE;
                        end
                    end
                end
            endcase
        end else if (tmo_q == TMO_LAST) begin
            tmo_d         = '0;
            state_d       = ST_IDLE;
            shift_d       = '0;
            bit_cnt_d     = '0;
            word_cnt_d    = '0;
            zero_cnt_d    = '0;
            frame_error_d = (state_q == ST_PIXEL);
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sclk_q        <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            zero_cnt_q    <= '0;
            tmo_q         <= '0;
            pix_data_q    <= '0;
            pix_index_q   <= '0;
            pix_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_q        <= sclk_in;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            zero_cnt_q    <= zero_cnt_d;
            tmo_q         <= tmo_d;
            pix_data_q    <= pix_data_d;
            pix_index_q   <= pix_index_d;
            pix_valid_q   <= pix_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_index   = pix_index_q;
    assign pix_valid   = pix_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign in_frame    = (state_q == ST_SYNC) || (state_q == ST_PIXEL);

endmodule

// File: tb/tb_matrix_strip_rx.sv
// Directed bench for matrix_strip_rx: a bit-stream level decoder model checked every cycle,
// plus literal per-scenario expectations (counts, indices, timeout distance).
`timescale 1ns/1ps
module tb_matrix_strip_rx;
    localparam int NUM_LEDS     = 64;
    localparam int START_BITS   = 32;
    localparam int IDLE_TIMEOUT = 4096;

    localparam int M_HUNT    = 0;
    localparam int M_SYNC    = 1;
    localparam int M_COLLECT = 2;
    localparam int M_TAIL    = 3;

    localparam int LIN_POS [4] = '{0, 8, 16, 63};
`ifdef MATRIX_RX_SNAKE_EN
    localparam int LIT_IDX [4] = '{7, 8, 23, 63};
`else
    localparam int LIT_IDX [4] = '{0, 8, 16, 63};
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk_in = 1'b0;
    logic        sdat_in = 1'b0;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic [5:0]  pix_index;
    logic        frame_done;
    logic        frame_error;
    logic        in_frame;

    matrix_strip_rx #(
        .NUM_LEDS(NUM_LEDS),
        .START_BITS(START_BITS),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sclk_in(sclk_in),
        .sdat_in(sdat_in),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_index(pix_index),
        .frame_done(frame_done),
        .frame_error(frame_error),
        .in_frame(in_frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model state (bit-stream level)
    int          m_mode = M_HUNT;
    int          m_zeros = 0;
    int          m_nbits = 0;
    int          m_widx = 0;
    int          since = 0;
    logic [31:0] m_word = 32'd0;
    bit          exp_valid = 0;
    bit          exp_done = 0;
    bit          exp_err = 0;
    logic [31:0] exp_data = 32'd0;
    logic [5:0]  exp_index = 6'd0;
    bit          evt_flag = 0;
    bit          checking = 0;

    // Per-scenario observations of the DUT
    int          cnt_valid = 0;
    int          cnt_done = 0;
    int          cnt_err = 0;
    int          last_evt_cyc = 0;
    int          last_err_cyc = 0;
    int          idx65 = -1;
    logic [5:0]  seen_idx [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int display_pos(input int i);
`ifdef MATRIX_RX_SNAKE_EN
        int r;
        r = i / 8;
        if (r % 2 == 0) return r * 8 + 7 - (i % 8);
        return i;
`else
        return i;
`endif
    endfunction

    function automatic logic [31:0] word_val(input int k);
        return (k % 2 == 0) ? 32'hF00F0000 : 32'hF0000000;
    endfunction

    task automatic model_reset();
        m_mode = M_HUNT; m_zeros = 0; m_nbits = 0; m_widx = 0; since = 0;
        m_word = 32'd0; evt_flag = 0;
        exp_valid = 0; exp_done = 0; exp_err = 0; exp_data = 32'd0; exp_index = 6'd0;
    endtask

    task automatic model_bit(input bit b);
        evt_flag = 1;
        if (m_mode == M_HUNT || m_mode == M_TAIL) begin
            if (b) m_zeros = 0;
            else begin
                m_zeros++;
                if (m_zeros == START_BITS) begin m_zeros = 0; m_mode = M_SYNC; end
            end
        end else if (m_mode == M_SYNC) begin
            if (b) begin m_word = 32'd1; m_nbits = 1; m_widx = 0; m_mode = M_COLLECT; end
        end else begin
            m_word = m_word * 2 + 32'(b);
            m_nbits++;
            if (m_nbits == 32) begin
                m_nbits = 0;
                if (m_word[31:29] == 3'b111) begin
                    exp_valid = 1; exp_data = m_word; exp_index = 6'(display_pos(m_widx));
                    if (m_widx == NUM_LEDS - 1) begin
                        exp_done = 1; m_mode = M_TAIL; m_zeros = 0; m_widx = 0;
                    end else m_widx++;
                end else if (m_word == 32'd0) begin
                    exp_err = 1; m_mode = M_SYNC; m_widx = 0;
                end else begin
                    exp_err = 1; m_mode = M_HUNT; m_zeros = 0; m_widx = 0;
                end
            end
        end
    endtask

    // Per-cycle compare, sampled 2 ns after the active edge
    always @(posedge clk) begin
        #2;
        cyc++;
        if (reset) begin
            model_reset();
            checking = 1;
        end else if (evt_flag) begin
            evt_flag = 0; since = 0; last_evt_cyc = cyc;
        end else begin
            since++;
            if (since == IDLE_TIMEOUT) begin
                since = 0;
                if (m_mode == M_COLLECT) exp_err = 1;
                m_mode = M_HUNT; m_zeros = 0; m_nbits = 0; m_widx = 0;
            end
        end
        if (checking) begin
            check("pix_valid", pix_valid, exp_valid);
            check("frame_done", frame_done, exp_done);
            check("frame_error", frame_error, exp_err);
            check("pix_data", pix_data, exp_data);
            check("pix_index", pix_index, exp_index);
            check("in_frame", in_frame, (m_mode == M_SYNC || m_mode == M_COLLECT));
        end
        if (pix_valid) begin
            if (cnt_valid < 64) seen_idx[cnt_valid] = pix_index;
            if (cnt_valid == 64) idx65 = int'(pix_index);
            cnt_valid++;
        end
        if (frame_done) cnt_done++;
        if (frame_error) begin cnt_err++; last_err_cyc = cyc; end
        exp_valid = 0; exp_done = 0; exp_err = 0;
    end

    task automatic clear_counts();
        cnt_valid = 0; cnt_done = 0; cnt_err = 0; idx65 = -1;
        for (int k = 0; k < 64; k++) seen_idx[k] = 6'd0;
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        sdat_in = b;
        sclk_in = 1'b1;
        @(negedge clk);
        sclk_in = 1'b0;
        model_bit(b);
    endtask

    task automatic send_zeros(input int n);
        for (int k = 0; k < n; k++) send_bit(1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int k = 31; k > 31 - nbits; k--) send_bit(w[k]);
    endtask

    task automatic send_frame();
        send_zeros(32);
        for (int k = 0; k < NUM_LEDS; k++) send_word(word_val(k), 32);
        send_zeros(64);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 64; k++) seen_idx[k] = 6'd0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Single frame
        clear_counts();
        send_frame();
        idle(4);
        check("t1_valid_count", cnt_valid, 64);
        check("t1_done_count", cnt_done, 1);
        check("t1_err_count", cnt_err, 0);
        check("t1_last_data", pix_data, 32'hF0000000);
        check("t1_last_index", pix_index, 6'd63);
        for (int k = 0; k < 4; k++)
            check($sformatf("t1_index_of_word_%0d", LIN_POS[k]), seen_idx[LIN_POS[k]], LIT_IDX[k]);

        // Two frames back to back
        clear_counts();
        send_frame();
        send_frame();
        idle(4);
        check("t2_valid_count", cnt_valid, 128);
        check("t2_done_count", cnt_done, 2);
        check("t2_err_count", cnt_err, 0);
        check("t2_second_frame_first_index", idx65, LIT_IDX[0]);

        // Bad header on word 5, then recovery
        clear_counts();
        send_zeros(32);
        for (int k = 0; k < 5; k++) send_word(word_val(k), 32);
        send_word(32'h700F0000, 32);
        idle(4);
        check("t3_valid_count", cnt_valid, 5);
        check("t3_err_count", cnt_err, 1);
        check("t3_done_count", cnt_done, 0);
        check("t3_in_frame", in_frame, 0);
        clear_counts();
        send_zeros(32);
        for (int k = 0; k < 3; k++) send_word(word_val(k), 32);
        idle(4);
        check("t3_recover_valid_count", cnt_valid, 3);
        check("t3_recover_first_index", seen_idx[0], LIT_IDX[0]);
        check("t3_recover_err_count", cnt_err, 0);
        check("t3_recover_in_frame", in_frame, 1);

        // sclk stalls after 10 bits of word 3
        clear_counts();
        send_word(word_val(3), 10);
        idle(4100);
        check("t4_err_count", cnt_err, 1);
        check("t4_timeout_distance", last_err_cyc - last_evt_cyc, 4096);
        check("t4_valid_count", cnt_valid, 0);
        check("t4_in_frame", in_frame, 0);

        // Reset mid-word 20, then a clean frame
        send_zeros(32);
        for (int k = 0; k < 20; k++) send_word(word_val(k), 32);
        send_word(word_val(20), 15);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_reset_pix_data", pix_data, 32'd0);
        check("t5_reset_pix_index", pix_index, 6'd0);
        check("t5_reset_pix_valid", pix_valid, 0);
        check("t5_reset_in_frame", in_frame, 0);
        check("t5_reset_frame_error", frame_error, 0);
        clear_counts();
        send_frame();
        idle(4);
        check("t5_valid_count", cnt_valid, 64);
        check("t5_done_count", cnt_done, 1);
        check("t5_err_count", cnt_err, 0);
        check("t5_first_index", seen_idx[0], LIT_IDX[0]);
        check("t5_last_index", seen_idx[63], 6'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
